// File: rtl/mem_cmd_seq.sv
// mem_cmd_seq -- byte-stream command sequencer in front of a small DFF RAM.
//
// Decodes header bytes (NOP / WRITE / READ / FILL) arriving on a valid/ready
// command port, drives the RAM strobes from registered state, captures the
// registered read data and returns it on a valid/ready response port. FILL
// writes one data byte to every address from the start address up to the top
// of the RAM, one address per cycle, without wrapping.
//
// Ports
//   clk        : clock, all logic on posedge
//   rst        : synchronous active-high reset
//   cmd_data   : command/data byte          cmd_valid / cmd_ready : handshake
//   rsp_data   : read result                rsp_valid / rsp_ready : handshake
//   mem_addr   : RAM address                mem_wdata             : RAM write data
//   mem_wr_en  : RAM write strobe           mem_r_en              : RAM read strobe
//   mem_rdata  : RAM registered read data   busy                  : not idle
module mem_cmd_seq #(
   parameter int unsigned ADDR_BITS = 4,
   parameter int unsigned READ_LAT  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           cmd_data,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   output logic [7:0]           rsp_data,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic                 mem_wr_en,
   output logic                 mem_r_en,
   output logic [7:0]           mem_wdata,
   input  logic [7:0]           mem_rdata,
   output logic                 busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_DATA,
      S_WRITE,
      S_FILL,
      S_READ_REQ,
      S_READ_WAIT,
      S_RESP
   } state_e;

   typedef enum logic [1:0] {
      OP_NOP   = 2'b00,
      OP_WRITE = 2'b01,
      OP_READ  = 2'b10,
      OP_FILL  = 2'b11
   } op_e;

   localparam int unsigned CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   state_e                 state_q;
   logic                   fill_q;
   logic [ADDR_BITS-1:0]   addr_q;
   logic [ADDR_BITS-1:0]   mem_addr_q;
   logic [7:0]             mem_wdata_q;
   logic                   mem_wr_en_q;
   logic                   mem_r_en_q;
   logic [7:0]             rsp_data_q;
   logic [CW-1:0]          wait_q;

   logic                   accept;
   op_e                    hdr_op;
   logic [ADDR_BITS-1:0]   hdr_addr;

   assign cmd_ready = (state_q == S_IDLE) || (state_q == S_GET_DATA);
   assign accept    = cmd_valid & cmd_ready;
   assign hdr_op    = op_e'(cmd_data[7:6]);
   assign hdr_addr  = cmd_data[ADDR_BITS-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         fill_q      <= 1'b0;
         addr_q      <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wr_en_q <= 1'b0;
         mem_r_en_q  <= 1'b0;
         rsp_data_q  <= '0;
         wait_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  case (hdr_op)
                     OP_WRITE, OP_FILL: begin
                        addr_q  <= hdr_addr;
                        fill_q  <= (hdr_op == OP_FILL);
                        state_q <= S_GET_DATA;
                     end
                     OP_READ: begin
                        // Read address goes straight to the pins so r_en is
                        // high in the cycle right after the header edge.
                        mem_addr_q <= hdr_addr;
                        mem_r_en_q <= 1'b1;
                        state_q    <= S_READ_REQ;
                     end
                     default: state_q <= S_IDLE;
                  endcase
               end
            end
            S_GET_DATA: begin
               if (accept) begin
                  mem_addr_q  <= addr_q;
                  mem_wdata_q <= cmd_data;
                  mem_wr_en_q <= 1'b1;
                  state_q     <= fill_q ? S_FILL : S_WRITE;
               end
            end
            S_WRITE: begin
               mem_wr_en_q <= 1'b0;
               state_q     <= S_IDLE;
            end
            S_FILL: begin
               // Terminate on the all-ones address rather than on counter
               // overflow, so the walk never wraps back to address 0.
               if (mem_addr_q == '1) begin
                  mem_wr_en_q <= 1'b0;
                  state_q     <= S_IDLE;
               end else begin
                  mem_addr_q <= mem_addr_q + ADDR_BITS'(1);
               end
            end
            S_READ_REQ: begin
               mem_r_en_q <= 1'b0;
               wait_q     <= '0;
               state_q    <= S_READ_WAIT;
            end
            S_READ_WAIT: begin
               if (wait_q == CW'(READ_LAT - 1)) begin
                  rsp_data_q <= mem_rdata;
                  state_q    <= S_RESP;
               end else begin
                  wait_q <= wait_q + CW'(1);
               end
            end
            S_RESP: begin
               if (rsp_ready) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid = (state_q == S_RESP);
   assign busy      = (state_q != S_IDLE);
   assign rsp_data  = rsp_data_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wr_en = mem_wr_en_q;
   assign mem_r_en  = mem_r_en_q;

endmodule

// File: tb/tb_mem_cmd_seq.sv
// Bench for mem_cmd_seq with a behavioural 16-byte RAM (read latency 1).
// Write and read strobes are logged by a monitor; each scenario task pushes the
// write events / read data it expects and compares them against the log.
module tb_mem_cmd_seq;
   localparam int unsigned AB = 4;
   localparam int unsigned RL = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    cmd_data = '0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [7:0]    rsp_data;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [AB-1:0] mem_addr;
   logic          mem_wr_en;
   logic          mem_r_en;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_rdata;
   logic          busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [7:0]  ram [16];
   logic [7:0]  ref_mem [16];
   bit          ram_init_done = 1'b0;
   logic [31:0] exp_wr [$];
   logic [31:0] obs_wr [$];
   logic [31:0] obs_rd [$];
   logic [7:0]  exp_rsp [$];

   mem_cmd_seq #(.ADDR_BITS(AB), .READ_LAT(RL)) dut (
      .clk(clk), .rst(rst),
      .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_r_en(mem_r_en),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (!ram_init_done) begin
         for (int i = 0; i < 16; i++) ram[i] <= 8'h10 + 8'(i);
         ram_init_done <= 1'b1;
      end else if (mem_wr_en) begin
         ram[mem_addr] <= mem_wdata;
      end
      if (mem_r_en) mem_rdata <= ram[mem_addr];
   end

   always @(negedge clk) begin
      if (mem_wr_en) obs_wr.push_back({16'(cyc), 4'h0, mem_addr, mem_wdata});
      if (mem_r_en)  obs_rd.push_back({16'(cyc), 12'h0, mem_addr});
      n_cmp++;
      assert (!(mem_wr_en && mem_r_en)) else begin
         n_err++;
         $display("FAIL strobe_excl got wr=%b rd=%b exp not both 1", mem_wr_en, mem_r_en);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got no finish exp finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b, output int acc, output int waited);
      @(negedge clk);
      cmd_data  = b;
      cmd_valid = 1'b1;
      waited    = 0;
      while (!cmd_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL accept_timeout got cmd_ready=%b exp 1 for byte %h", cmd_ready, b);
      end
      @(posedge clk);
      #1;
      acc       = cyc;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int at, output bit ok);
      int n = 0;
      ok = 1'b0;
      at = 0;
      while (n < 50 && !ok) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            ok = 1'b1;
            at = cyc;
         end
         n++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({cmd_ready, rsp_valid, mem_wr_en, mem_r_en, busy} !== 5'b10000) begin
         n_err++;
         $display("FAIL reset_ctrl got rdy,rv,wr,rd,busy=%b exp 10000",
                  {cmd_ready, rsp_valid, mem_wr_en, mem_r_en, busy});
      end
      n_cmp++;
      if ({rsp_data, mem_addr, mem_wdata} !== 20'h0) begin
         n_err++;
         $display("FAIL reset_data got rsp=%h addr=%h wdata=%h exp 0", rsp_data, mem_addr, mem_wdata);
      end
      rst = 1'b0;
   endtask

   task automatic test_write;
      int a, k, w;
      logic [31:0] e, o;
      obs_wr.delete();
      send_byte(8'h45, a, w);
      send_byte(8'hA5, k, w);
      exp_wr.push_back({16'(k), 4'h0, 4'h5, 8'hA5});
      ref_mem[5] = 8'hA5;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({mem_wr_en, mem_addr, mem_wdata} !== {1'b0, 4'h5, 8'hA5}) begin
         n_err++;
         $display("FAIL write_hold got wr=%b addr=%h wdata=%h exp 0 5 a5", mem_wr_en, mem_addr, mem_wdata);
      end
      n_cmp++;
      if (obs_wr.size() != exp_wr.size()) begin
         n_err++;
         $display("FAIL write_count got %0d exp %0d", obs_wr.size(), exp_wr.size());
      end
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         e = exp_wr.pop_front();
         o = obs_wr.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL write_ev got cyc=%0d a=%h d=%h exp cyc=%0d a=%h d=%h",
                     o[31:16], o[11:8], o[7:0], e[31:16], e[11:8], e[7:0]);
         end
      end
      exp_wr.delete();
      obs_wr.delete();
   endtask

   task automatic test_read;
      int t, w, vc;
      bit ok;
      logic [7:0] d, e;
      obs_rd.delete();
      exp_rsp.push_back(ref_mem[5]);
      send_byte(8'h85, t, w);
      wait_rsp(vc, ok);
      n_cmp++;
      if (!ok || vc != t + 1 + int'(RL)) begin
         n_err++;
         $display("FAIL read_latency got ok=%0d cyc=%0d exp cyc=%0d", ok, vc, t + 1 + int'(RL));
      end
      n_cmp++;
      if (obs_rd.size() != 1 || obs_rd[0] !== {16'(t), 12'h0, 4'h5}) begin
         n_err++;
         $display("FAIL read_strobe got n=%0d first=%h exp 1 pulse at cyc %0d addr 5",
                  obs_rd.size(), (obs_rd.size() > 0) ? obs_rd[0] : 32'h0, t);
      end
      d = rsp_data;
      e = exp_rsp.pop_front();
      n_cmp++;
      if (d !== e) begin
         n_err++;
         $display("FAIL read_data got %h exp %h", d, e);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({rsp_valid, cmd_ready, rsp_data} !== {1'b1, 1'b0, e}) begin
            n_err++;
            $display("FAIL read_hold got rv=%b rdy=%b data=%h exp 1 0 %h", rsp_valid, cmd_ready, rsp_data, e);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      n_cmp++;
      if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
         n_err++;
         $display("FAIL read_release got rv,rdy,busy=%b exp 010", {rsp_valid, cmd_ready, busy});
      end
      obs_rd.delete();
   endtask

   task automatic test_readback(input int lo, input int hi);
      int t, w, vc;
      bit ok;
      logic [7:0] e;
      for (int a = lo; a <= hi; a++) begin
         exp_rsp.push_back(ref_mem[a]);
         send_byte({4'b1000, 4'(a)}, t, w);
         wait_rsp(vc, ok);
         e = exp_rsp.pop_front();
         n_cmp++;
         if (!ok || rsp_data !== e) begin
            n_err++;
            $display("FAIL readback addr %0d got ok=%0d data=%h exp %h", a, ok, rsp_data, e);
         end
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
      end
      obs_rd.delete();
   endtask

   task automatic test_fill;
      int a, k, w;
      logic [31:0] e, o;
      obs_wr.delete();
      send_byte(8'hCC, a, w);
      send_byte(8'h3C, k, w);
      for (int i = 0; i < 4; i++) begin
         exp_wr.push_back({16'(k + i), 4'h0, 4'(12 + i), 8'h3C});
         ref_mem[12 + i] = 8'h3C;
      end
      repeat (8) @(negedge clk);
      send_byte(8'hCF, a, w);
      send_byte(8'h77, k, w);
      exp_wr.push_back({16'(k), 4'h0, 4'hF, 8'h77});
      ref_mem[15] = 8'h77;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (obs_wr.size() != exp_wr.size()) begin
         n_err++;
         $display("FAIL fill_count got %0d exp %0d", obs_wr.size(), exp_wr.size());
      end
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         e = exp_wr.pop_front();
         o = obs_wr.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL fill_ev got cyc=%0d a=%h d=%h exp cyc=%0d a=%h d=%h",
                     o[31:16], o[11:8], o[7:0], e[31:16], e[11:8], e[7:0]);
         end
      end
      exp_wr.delete();
      obs_wr.delete();
      test_readback(11, 15);
   endtask

   task automatic test_nop_stall;
      int a, k, w;
      logic [31:0] e, o;
      obs_wr.delete();
      obs_rd.delete();
      send_byte(8'h00, a, w);
      repeat (4) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || obs_wr.size() != 0 || obs_rd.size() != 0) begin
         n_err++;
         $display("FAIL nop got busy=%b wr=%0d rd=%0d exp 0 0 0", busy, obs_wr.size(), obs_rd.size());
      end
      send_byte(8'h42, a, w);
      repeat (5) @(negedge clk);
      n_cmp++;
      if ({busy, cmd_ready} !== 2'b11 || obs_wr.size() != 0) begin
         n_err++;
         $display("FAIL stall got busy=%b rdy=%b wr=%0d exp 1 1 0", busy, cmd_ready, obs_wr.size());
      end
      send_byte(8'h99, k, w);
      exp_wr.push_back({16'(k), 4'h0, 4'h2, 8'h99});
      ref_mem[2] = 8'h99;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (obs_wr.size() != exp_wr.size()) begin
         n_err++;
         $display("FAIL stall_count got %0d exp %0d", obs_wr.size(), exp_wr.size());
      end
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         e = exp_wr.pop_front();
         o = obs_wr.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL stall_ev got cyc=%0d a=%h d=%h exp cyc=%0d a=%h d=%h",
                     o[31:16], o[11:8], o[7:0], e[31:16], e[11:8], e[7:0]);
         end
      end
      exp_wr.delete();
      obs_wr.delete();
   endtask

   task automatic test_back_to_back;
      int a, k, h2, w;
      logic [31:0] e, o;
      obs_wr.delete();
      send_byte(8'h47, a, w);
      send_byte(8'h01, k, w);
      send_byte(8'h48, h2, w);
      n_cmp++;
      if (h2 != k + 2) begin
         n_err++;
         $display("FAIL b2b_accept got edge %0d exp %0d", h2, k + 2);
      end
      exp_wr.push_back({16'(k), 4'h0, 4'h7, 8'h01});
      send_byte(8'h02, k, w);
      exp_wr.push_back({16'(k), 4'h0, 4'h8, 8'h02});
      ref_mem[7] = 8'h01;
      ref_mem[8] = 8'h02;
      repeat (3) @(negedge clk);
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         e = exp_wr.pop_front();
         o = obs_wr.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL b2b_ev got cyc=%0d a=%h d=%h exp cyc=%0d a=%h d=%h",
                     o[31:16], o[11:8], o[7:0], e[31:16], e[11:8], e[7:0]);
         end
      end
      n_cmp++;
      if (exp_wr.size() != 0 || obs_wr.size() != 0) begin
         n_err++;
         $display("FAIL b2b_count got leftover obs=%0d exp=%0d, exp 0 0", obs_wr.size(), exp_wr.size());
      end
      exp_wr.delete();
      obs_wr.delete();
   endtask

   task automatic test_reset_fill;
      int a, k, w;
      logic [31:0] e, o;
      obs_wr.delete();
      send_byte(8'hC0, a, w);
      send_byte(8'h5A, k, w);
      for (int i = 0; i < 3; i++) begin
         exp_wr.push_back({16'(k + i), 4'h0, 4'(i), 8'h5A});
         ref_mem[i] = 8'h5A;
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({mem_wr_en, mem_r_en, busy, cmd_ready, rsp_valid, mem_addr} !== {5'b00010, 4'h0}) begin
         n_err++;
         $display("FAIL rst_fill got wr=%b rd=%b busy=%b rdy=%b rv=%b addr=%h exp 0 0 0 1 0 0",
                  mem_wr_en, mem_r_en, busy, cmd_ready, rsp_valid, mem_addr);
      end
      rst = 1'b0;
      send_byte(8'h41, a, w);
      n_cmp++;
      if (w != 0) begin
         n_err++;
         $display("FAIL rst_fill_next got wait %0d exp 0", w);
      end
      send_byte(8'h11, k, w);
      exp_wr.push_back({16'(k), 4'h0, 4'h1, 8'h11});
      ref_mem[1] = 8'h11;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (obs_wr.size() != exp_wr.size()) begin
         n_err++;
         $display("FAIL rst_fill_count got %0d exp %0d", obs_wr.size(), exp_wr.size());
      end
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         e = exp_wr.pop_front();
         o = obs_wr.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL rst_fill_ev got cyc=%0d a=%h d=%h exp cyc=%0d a=%h d=%h",
                     o[31:16], o[11:8], o[7:0], e[31:16], e[11:8], e[7:0]);
         end
      end
      exp_wr.delete();
      obs_wr.delete();
      test_readback(0, 15);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) ref_mem[i] = 8'h10 + 8'(i);
      test_reset();
      test_write();
      test_read();
      test_fill();
      test_nop_stall();
      test_back_to_back();
      test_reset_fill();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
